latch_rf_write_seq: RTL

- Write sequencer placed directly upstream of a bank of transparent-high D latches (latq-type cells) that form a latch-based register file.
- Accepts single-word write requests over a valid/ready handshake and registers the write data onto the shared latch D bus.
- Generates a glitch-free, registered, one-hot enable pulse for the addressed word.
- Enforces setup (D stable before E rises) and hold (D stable after E falls) in whole clock cycles.

---
 rtl/latch_rf_write_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/latch_rf_write_seq.sv
// rtl/latch_rf_write_seq.sv - Write sequencer for a latch-based register file.
// Registers D, then pulses a one-hot latch enable with whole-cycle setup and hold margins.
module latch_rf_write_seq #(
    parameter int WORDS       = 8,
    parameter int WIDTH       = 8,
    parameter int AW          = 3,
    parameter int OPEN_CYCLES = 1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic [WIDTH-1:0] LAT_D,
    output logic [WORDS-1:0] LAT_E,
    output logic             BUSY,
    output logic             ERR
);

    localparam int MAXC = (OPEN_CYCLES > HOLD_CYCLES) ? OPEN_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [AW:0] WORDS_W = (AW + 1)'(WORDS);

    generate
        if (OPEN_CYCLES < 1 || HOLD_CYCLES < 1 || (2 ** AW) < WORDS) begin : g_bad_params
            $error("latch_rf_write_seq: illegal OPEN_CYCLES/HOLD_CYCLES/AW for WORDS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_lat_d;
    logic [WORDS-1:0] r_lat_e;
    logic             r_busy;
    logic             r_err;
    logic             w_ready;
    logic             w_accept;
    logic             w_in_range;

    assign w_ready    = (r_state == S_IDLE) & ~RST;
    assign w_accept   = WR_VALID & w_ready;
    assign w_in_range = {1'b0, WR_ADDR} < WORDS_W;

    assign WR_READY = w_ready;
    assign LAT_D    = r_lat_d;
    assign LAT_E    = r_lat_e;
    assign BUSY     = r_busy;
    assign ERR      = r_err;

    // Counter is loaded with (cycles-1) on entry so the phase ends when it reads zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_in_range) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_OPEN;
                w_cnt_nxt   = CW'(OPEN_CYCLES - 1);
            end
            S_OPEN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_lat_d <= '0;
            r_lat_e <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_err   <= w_accept & ~w_in_range;
            if (w_accept) begin
                r_addr  <= WR_ADDR;
                r_lat_d <= WR_DATA;
            end
            // Enables are decoded before the flop so the latch E pins see only flop outputs.
            if (r_state == S_SETUP) begin
                r_lat_e <= WORDS'(1) << r_addr;
            end else if (r_state == S_OPEN && r_cnt == '0) begin
                r_lat_e <= '0;
            end
        end
    end

endmodule
